// File: rtl/aes_pkg.sv
// Shared types, round constants and byte-level helpers for the AES-128 inverse cipher.
// Byte k of a 128-bit block sits at bits [127-8k -: 8]; column c holds bytes 4c..4c+3.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } aes_state_t;

  localparam logic SBOX_FWD = 1'b0;
  localparam logic SBOX_INV = 1'b1;

  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // Indices past the table only occur in idle cycles; they map to zero.
  function automatic logic [7:0] rcon_at(input logic [3:0] i);
    return (i < 4'd10) ? RCON[i] : 8'h00;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] res;
    logic [7:0]   a0, a1, a2, a3;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      res[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      res[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      res[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      res[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_decrypt_core_sbox.sv
// One-byte AES S-box, forward or inverse selected by mode, built from GF(2^8)
// inversion (x^254) and the affine map, with no lookup table.
module aes_sbox
  import aes_pkg::*;
(
  input  logic       mode,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // x^254 = product of x^2, x^4, ..., x^128; zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  assign dout = (mode == SBOX_INV) ? gf_inv(inv_affine(din)) : fwd_affine(gf_inv(din));

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryption, one inverse round per clock, with the last round
// key derived by forward expansion and cached so repeat-key blocks skip it.
module aes_decrypt_core
  import aes_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; in_ready is high only in IDLE, and out/out_valid hold until out_ready.
  aes_state_t   fsm, fsm_nxt;
  logic [127:0] st, key_reg, cache_key, cache_rk10;
  logic         cache_valid;
  logic [3:0]   rnd, rc_idx;
  logic         accept, hit;
  logic [31:0]  w0, w1, w2, w3, sub_in, sub_rot, sub_out, rc_word;
  logic [127:0] fwd_next, rk_prev, isr, isb, t;

  assign accept = in_valid && in_ready;
  assign hit    = cache_valid && (key == cache_key);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm      <= IDLE;
      in_ready <= 1'b0;
    end else begin
      fsm      <= fsm_nxt;
      in_ready <= (fsm_nxt == IDLE);
    end
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (accept) fsm_nxt = hit ? ROUND : KEYEXP;
      KEYEXP:  if (rc_idx == 4'd9) fsm_nxt = ROUND;
      ROUND:   if (rnd == 4'd0) fsm_nxt = DONE;
      DONE:    if (out_ready) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (fsm == DONE);
    busy      = (fsm != IDLE);
    dbg_state = fsm;
  end

  // The four forward S-boxes serve forward_next in KEYEXP and inverse_prev in ROUND.
  assign {w0, w1, w2, w3} = key_reg;
  assign sub_in  = (fsm == KEYEXP) ? w3 : (w3 ^ w2);
  assign sub_rot = rot_word(sub_in);
  assign rc_word = {rcon_at((fsm == KEYEXP) ? rc_idx : rnd), 24'h000000};

  always_comb begin
    fwd_next[127:96] = w0 ^ sub_out ^ rc_word;
    fwd_next[95:64]  = w1 ^ fwd_next[127:96];
    fwd_next[63:32]  = w2 ^ fwd_next[95:64];
    fwd_next[31:0]   = w3 ^ fwd_next[63:32];
    rk_prev[31:0]    = w3 ^ w2;
    rk_prev[63:32]   = w2 ^ w1;
    rk_prev[95:64]   = w1 ^ w0;
    rk_prev[127:96]  = w0 ^ sub_out ^ rc_word;
  end

  assign isr = inv_shift_rows(st);
  assign t   = isb ^ rk_prev;

  for (genvar g = 0; g < 4; g++) begin : g_key_sbox
    aes_sbox u_sbox (.mode(SBOX_FWD), .din(sub_rot[31-8*g -: 8]), .dout(sub_out[31-8*g -: 8]));
  end

  for (genvar g = 0; g < 16; g++) begin : g_state_sbox
    aes_sbox u_sbox (.mode(SBOX_INV), .din(isr[127-8*g -: 8]), .dout(isb[127-8*g -: 8]));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st          <= '0;
      key_reg     <= '0;
      cache_key   <= '0;
      cache_rk10  <= '0;
      cache_valid <= 1'b0;
      rnd         <= '0;
      rc_idx      <= '0;
      out         <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (accept && hit) begin
            key_reg <= cache_rk10;
            st      <= in ^ cache_rk10;
            rnd     <= 4'd9;
          end else if (accept) begin
            // cache_key doubles as the latched key; the entry is invalid until rk10 lands.
            key_reg     <= key;
            st          <= in;
            rc_idx      <= 4'd0;
            cache_key   <= key;
            cache_valid <= 1'b0;
          end
        end
        KEYEXP: begin
          key_reg <= fwd_next;
          rc_idx  <= rc_idx + 4'd1;
          if (rc_idx == 4'd9) begin
            st          <= st ^ fwd_next;
            cache_rk10  <= fwd_next;
            cache_valid <= 1'b1;
            rnd         <= 4'd9;
          end
        end
        ROUND: begin
          key_reg <= rk_prev;
          if (rnd == 4'd0) begin
            st  <= t;
            out <= t;
          end else begin
            st  <= inv_mix_columns(t);
            rnd <= rnd - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed bench for aes_decrypt_core: a table-driven AES model supplies expected
// plaintexts and latencies; one negedge process checks outputs every cycle.
module tb_aes_decrypt_core;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_d = '0;
  logic [127:0] key_d = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_d;
  logic [1:0]   dbg_state;

  aes_decrypt_core dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in(in_d), .key(key_d), .out_valid(out_valid), .out_ready(out_ready),
    .out(out_d), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [127:0] exp_q[$];
  int           n_vec = 0;
  int           n_fail = 0;
  logic         mdl_cv = 1'b0;
  logic [127:0] mdl_ck = '0;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural AES model ----------------
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, cst;
    cst = 8'h63;
    for (int xv = 0; xv < 256; xv++) begin
      inv = 8'h00;
      for (int yv = 1; yv < 256; yv++)
        if (gm(8'(xv), 8'(yv)) == 8'h01) inv = 8'(yv);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sb[xv]  = s;
      isb[s]  = 8'(xv);
    end
  endtask

  function automatic logic [127:0] mdl_round_key(input logic [127:0] k, input int r);
    logic [31:0] w [4];
    logic [31:0] tw;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int rr = 1; rr <= r; rr++) begin
      tw = {w[3][23:0], w[3][31:24]};
      tw = {sb[tw[31:24]], sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]]} ^ {rc, 24'h0};
      w[0] = w[0] ^ tw;
      w[1] = w[1] ^ w[0];
      w[2] = w[2] ^ w[1];
      w[3] = w[3] ^ w[2];
      rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
    end
    return {w[0], w[1], w[2], w[3]};
  endfunction

  function automatic logic [127:0] mdl_decrypt(input logic [127:0] ct, input logic [127:0] k);
    logic [7:0]   s [16];
    logic [7:0]   tt [16];
    logic [127:0] rk, res;
    logic [7:0]   a0, a1, a2, a3;
    rk = mdl_round_key(k, 10);
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int rr = 9; rr >= 0; rr--) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          tt[row + 4*((c+row)%4)] = s[row + 4*c];
      rk = mdl_round_key(k, rr);
      for (int i = 0; i < 16; i++) s[i] = isb[tt[i]] ^ rk[127-8*i -: 8];
      if (rr != 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
          s[4*c+1] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
          s[4*c+2] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
          s[4*c+3] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (reset_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL spurious_out: out_valid=1 out=%h with nothing expected", out_d);
        end else begin
          check128("out", out_d, exp_q[0]);
        end
      end
      check_int("ready_vs_busy", int'(in_ready && busy), 0);
      check_int("valid_vs_busy", int'(out_valid && !busy), 0);
    end
  end

  always @(posedge clock)
    if (reset_n && out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());

  // ---------------- driver ----------------
  task automatic run_block(input logic [127:0] k, input logic [127:0] ct,
                           input int hold, input bit garbage, input bit do_reset);
    int exp_lat, acc, lat;
    bit got;
    exp_lat = (mdl_cv && k == mdl_ck) ? 10 : 20;
    @(negedge clock);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clock);
    if (!in_ready) begin
      check_int("accept_timeout", 0, 1);
      return;
    end
    in_valid  = 1'b1;
    in_d      = ct;
    key_d     = k;
    out_ready = (hold == 0);
    @(posedge clock);
    #1;
    acc = cyc;
    exp_q.push_back(mdl_decrypt(ct, k));
    mdl_cv = 1'b1;
    mdl_ck = k;
    @(negedge clock);
    in_valid = 1'b0;

    if (do_reset) begin
      repeat ((exp_lat == 10) ? 4 : 14) @(negedge clock);
      reset_n = 1'b0;
      exp_q.delete();
      mdl_cv = 1'b0;
      #1;
      check_int("midrst_in_ready", int'(in_ready), 0);
      check_int("midrst_out_valid", int'(out_valid), 0);
      check_int("midrst_busy", int'(busy), 0);
      check128("midrst_out", out_d, 128'h0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check_int("midrst_ready_after", int'(in_ready), 1);
      return;
    end

    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      if (garbage) begin
        in_valid = 1'($urandom_range(0, 1));
        in_d     = {$urandom, $urandom, $urandom, $urandom};
        key_d    = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    if (!got) begin
      check_int("out_valid_timeout", 0, 1);
      return;
    end
    lat = cyc - acc;
    check_int("latency", lat, exp_lat);

    for (int i = 0; i < hold; i++) begin
      check_int("hold_out_valid", int'(out_valid), 1);
      check_int("hold_in_ready", int'(in_ready), 0);
      @(negedge clock);
    end
    out_ready = 1'b1;
    @(negedge clock);
    check_int("release_out_valid", int'(out_valid), 0);
    check_int("release_in_ready", int'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    build_tables();
    check_int("model_sbox_00", int'(sb[0]), 'h63);
    check_int("model_isbox_16", int'(isb[8'h16]), 'hff);
    check128("model_rk10", mdl_round_key(K1, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check128("model_p1", mdl_decrypt(C1, K1), P1);
    check128("model_p2", mdl_decrypt(C2, K2), P2);

    repeat (3) @(negedge clock);
    check_int("rst_in_ready", int'(in_ready), 0);
    check_int("rst_out_valid", int'(out_valid), 0);
    check_int("rst_busy", int'(busy), 0);
    check128("rst_out", out_d, 128'h0);
    reset_n = 1'b1;
    @(negedge clock);
    check_int("ready_after_reset", int'(in_ready), 1);

    run_block(K1, C1, 0, 1'b0, 1'b0);   // miss
    run_block(K1, C1, 0, 1'b0, 1'b0);   // hit
    run_block(K2, C2, 0, 1'b0, 1'b0);   // key change
    run_block(K1, C1, 0, 1'b0, 1'b0);   // miss again after change
    run_block(K1, C1, 7, 1'b0, 1'b0);   // hit with backpressure
    run_block(K1, C1, 0, 1'b0, 1'b1);   // reset during round 5
    run_block(K1, C1, 0, 1'b0, 1'b0);   // cache cleared by reset
    run_block(K2, C2, 0, 1'b1, 1'b0);   // garbage while busy, miss
    run_block(K2, C2, 3, 1'b1, 1'b0);   // garbage while busy, hit

    repeat (30) @(negedge clock);
    check_int("final_busy", int'(busy), 0);
    check_int("final_out_valid", int'(out_valid), 0);
    check_int("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
